memwb_skid_stage: RTL and testbench

Elastic MEM→WB pipeline stage with a 2-entry skid buffer. It replaces the plain enable/clear MEM/WB register with a valid/ready handshake, so a stalled writeback port never needs a combinational back-pressure path into MEM. Load data is selected at capture time, with optional sub-word alignment. Scalar and vector writeback payloads are carried together, and the stage keeps a saturating count of entries squashed by flushes.

---
 rtl/memwb_skid_stage.sv | 219 +++++++++++++++++++++
 tb/tb_memwb_skid_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_skid_stage.sv
// ---------------------------------------------------------------------------
// memwb_skid_stage
//
// Elastic MEM->WB pipeline stage built around a two-slot skid buffer (MAIN and
// SKID). All out_* fields come from MAIN. in_ready is a pure function of the
// registered state, so there is no combinational out_ready -> in_ready path.
// The scalar writeback word is resolved when an entry is captured, so each
// slot holds the final XLEN value and not the raw memory fields.
//
// Optional feature macro: MEMWB_LOAD_ALIGN_EN
//   defined   : loads are lane-selected by in_addr_lo and sign- or zero-
//               extended according to in_load_type (LB/LH/LW/LBU/LHU).
//   undefined : in_ramdata passes through unchanged; in_addr_lo and
//               in_load_type are ignored.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           squash held and incoming entries (synchronous)
//   in_valid/in_ready MEM-side handshake (in_ready registered)
//   in_result         ALU / forwarded result
//   in_ramdata        raw memory read word
//   in_addr_lo        byte offset of the load address
//   in_load_type      funct3 of the load
//   in_memtoreg       choose memory data over in_result
//   in_regwrite/in_rd scalar write request and destination
//   in_vecwrite/in_vecdata  vector write request and payload
//   out_valid/out_ready     WB-side handshake
//   out_wb_data, out_rd, out_regwrite, out_vecwrite, out_vecdata  head entry
//   out_count         occupancy 0..2
//   flush_drops       saturating count of valid entries discarded by flush
// ---------------------------------------------------------------------------
module memwb_skid_stage #(
    parameter int XLEN   = 32,
    parameter int VLEN   = 64,
    parameter int RD_W   = 5,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_ramdata,
    input  logic [1:0]        in_addr_lo,
    input  logic [2:0]        in_load_type,
    input  logic              in_memtoreg,
    input  logic              in_regwrite,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_vecwrite,
    input  logic [VLEN-1:0]   in_vecdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_wb_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_regwrite,
    output logic              out_vecwrite,
    output logic [VLEN-1:0]   out_vecdata,
    output logic [1:0]        out_count,
    output logic [FCNT_W-1:0] flush_drops
);

    typedef struct packed {
        logic [XLEN-1:0] wb_data;
        logic [RD_W-1:0] rd;
        logic            regwrite;
        logic            vecwrite;
        logic [VLEN-1:0] vecdata;
    } slot_t;

    // Encoding equals the occupancy, so out_count is the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    slot_t             main_q, main_d;
    slot_t             skid_q, skid_d;
    logic [FCNT_W-1:0] flush_drops_q, flush_drops_d;

    logic              in_fire;
    logic              out_fire;
    logic [XLEN-1:0]   load_data;
    slot_t             new_slot;

    // -----------------------------------------------------------------------
    // Load data selection
    // -----------------------------------------------------------------------
`ifdef MEMWB_LOAD_ALIGN_EN
    logic [7:0]  ram_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign ram_byte[gi] = in_ramdata[gi*8 +: 8];
    end

    assign sel_byte = ram_byte[in_addr_lo];
    // Half lane only looks at addr_lo[1]; a misaligned bit 0 is ignored.
    assign sel_half = in_addr_lo[1] ? in_ramdata[31:16] : in_ramdata[15:0];

    always_comb begin
        load_data = in_ramdata;
        case (in_load_type)
            3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
            default: load_data = in_ramdata;
        endcase
    end
`else
    logic unused_align_inputs;
    assign unused_align_inputs = ^{in_addr_lo, in_load_type};
    assign load_data = in_ramdata;
`endif

    // -----------------------------------------------------------------------
    // Handshake and next-state logic
    // -----------------------------------------------------------------------
    assign in_ready = (state_q != ST_TWO);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = (state_q != ST_EMPTY) & out_ready;

    always_comb begin
        new_slot.wb_data  = in_memtoreg ? load_data : in_result;
        new_slot.rd       = in_rd;
        new_slot.regwrite = in_regwrite;
        new_slot.vecwrite = in_vecwrite;
        new_slot.vecdata  = in_vecdata;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush_i) begin
            // Slot contents are left as-is; only occupancy is cleared.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = new_slot;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = new_slot;
                    end else if (in_fire) begin
                        skid_d  = new_slot;
                        state_d = ST_TWO;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Flush drop counter: entries delivered in the flush cycle are not drops.
    // -----------------------------------------------------------------------
    logic [1:0]      drop_add;
    logic [FCNT_W:0] drop_sum;

    always_comb begin
        drop_add      = state_q - {1'b0, out_fire} + {1'b0, in_fire};
        drop_sum      = {1'b0, flush_drops_q} + {{(FCNT_W-1){1'b0}}, drop_add};
        flush_drops_d = flush_drops_q;
        if (flush_i) begin
            flush_drops_d = drop_sum[FCNT_W] ? {FCNT_W{1'b1}} : drop_sum[FCNT_W-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            main_q        <= '0;
            flush_drops_q <= '0;
        end else begin
            state_q       <= state_d;
            main_q        <= main_d;
            flush_drops_q <= flush_drops_d;
        end
    end

    // SKID is only ever read while the state says it is occupied.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_count    = state_q;
    assign out_valid    = (state_q != ST_EMPTY);
    assign out_wb_data  = main_q.wb_data;
    assign out_rd       = main_q.rd;
    assign out_regwrite = main_q.regwrite & (main_q.rd != '0);
    assign out_vecwrite = main_q.vecwrite;
    assign out_vecdata  = main_q.vecdata;
    assign flush_drops  = flush_drops_q;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed testbench for memwb_skid_stage (narrow flush counter so that
// saturation is reached quickly).
module tb_memwb_skid_stage;

    localparam int XLEN   = 32;
    localparam int VLEN   = 64;
    localparam int RD_W   = 5;
    localparam int FCNT_W = 4;

    logic              clk;
    logic              rst_n;
    logic              flush_i;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_result;
    logic [XLEN-1:0]   in_ramdata;
    logic [1:0]        in_addr_lo;
    logic [2:0]        in_load_type;
    logic              in_memtoreg;
    logic              in_regwrite;
    logic [RD_W-1:0]   in_rd;
    logic              in_vecwrite;
    logic [VLEN-1:0]   in_vecdata;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_wb_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_regwrite;
    logic              out_vecwrite;
    logic [VLEN-1:0]   out_vecdata;
    logic [1:0]        out_count;
    logic [FCNT_W-1:0] flush_drops;

    int checks = 0;
    int errors = 0;

    memwb_skid_stage #(
        .XLEN(XLEN), .VLEN(VLEN), .RD_W(RD_W), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_ramdata(in_ramdata),
        .in_addr_lo(in_addr_lo), .in_load_type(in_load_type),
        .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_rd(in_rd),
        .in_vecwrite(in_vecwrite), .in_vecdata(in_vecdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_data(out_wb_data), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_vecwrite(out_vecwrite),
        .out_vecdata(out_vecdata), .out_count(out_count),
        .flush_drops(flush_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are
    // sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [XLEN-1:0] result, input logic [RD_W-1:0] rd,
                         input logic regwrite);
        in_valid    = 1'b1;
        in_result   = result;
        in_memtoreg = 1'b0;
        in_rd       = rd;
        in_regwrite = regwrite;
        in_vecwrite = 1'b0;
    endtask

    task automatic offer_load(input logic [XLEN-1:0] ram, input logic [1:0] lo,
                              input logic [2:0] lt);
        in_valid     = 1'b1;
        in_result    = 32'hCCCC_CCCC;
        in_ramdata   = ram;
        in_addr_lo   = lo;
        in_load_type = lt;
        in_memtoreg  = 1'b1;
        in_rd        = 5'd7;
        in_regwrite  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", out_count); end
        checks++;
        if (flush_drops !== '0) begin errors++; $display("FAIL reset_drops: got %0d expected 0", flush_drops); end
        checks++;
        if ({out_regwrite, out_vecwrite} !== 2'b00) begin errors++; $display("FAIL reset_we: got %b expected 00", {out_regwrite, out_vecwrite}); end
        checks++;
        if (out_wb_data !== '0 || out_rd !== '0 || out_vecdata !== '0) begin
            errors++; $display("FAIL reset_data: got wb=%h rd=%0d vec=%h expected zeros", out_wb_data, out_rd, out_vecdata);
        end
        checks++;
        rst_n = 1'b1;
        tick();
        $display("reset: count=%0d in_ready=%b", out_count, in_ready);
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        offer(32'h0000_1234, 5'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        if (out_valid !== 1'b1 || out_wb_data !== 32'h1234) begin
            errors++; $display("FAIL single_data: got v=%b wb=%h expected v=1 wb=00001234", out_valid, out_wb_data);
        end
        checks++;
        if (out_regwrite !== 1'b1 || out_rd !== 5'd5 || out_count !== 2'd1) begin
            errors++; $display("FAIL single_ctrl: got we=%b rd=%0d cnt=%0d expected 1 5 1", out_regwrite, out_rd, out_count);
        end
        checks++;
        tick();
        if (out_valid !== 1'b0 || out_count !== 2'd0) begin
            errors++; $display("FAIL single_drain: got v=%b cnt=%0d expected 0 0", out_valid, out_count);
        end
        checks++;
        $display("single: wb=%h delivered", 32'h1234);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        offer(32'hA, 5'd1, 1'b1);
        tick();
        if (out_count !== 2'd1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_a: got cnt=%0d rdy=%b expected 1 1", out_count, in_ready);
        end
        checks++;
        offer(32'hB, 5'd2, 1'b1);
        tick();
        if (out_count !== 2'd2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_b: got cnt=%0d rdy=%b expected 2 0", out_count, in_ready);
        end
        checks++;
        offer(32'hC, 5'd3, 1'b1);
        tick();
        if (out_count !== 2'd2 || out_wb_data !== 32'hA) begin
            errors++; $display("FAIL b2b_hold: got cnt=%0d wb=%h expected 2 0000000a", out_count, out_wb_data);
        end
        checks++;
        out_ready = 1'b1;
        tick();
        if (out_wb_data !== 32'hB || out_rd !== 5'd2 || out_count !== 2'd1) begin
            errors++; $display("FAIL b2b_out_b: got wb=%h rd=%0d cnt=%0d expected 0000000b 2 1", out_wb_data, out_rd, out_count);
        end
        checks++;
        tick();
        in_valid = 1'b0;
        if (out_wb_data !== 32'hC || out_count !== 2'd1) begin
            errors++; $display("FAIL b2b_out_c: got wb=%h cnt=%0d expected 0000000c 1", out_wb_data, out_count);
        end
        checks++;
        tick();
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_nodup: got v=%b expected 0", out_valid);
        end
        checks++;
        $display("back_to_back: A,B,C delivered");
    endtask

    task automatic test_align();
        logic [XLEN-1:0] exp_v [5];
        logic [1:0]      lo_v  [5];
        logic [2:0]      lt_v  [5];
        lo_v[0] = 2'd3; lt_v[0] = 3'b000;
        lo_v[1] = 2'd2; lt_v[1] = 3'b100;
        lo_v[2] = 2'd2; lt_v[2] = 3'b001;
        lo_v[3] = 2'd1; lt_v[3] = 3'b101;
        lo_v[4] = 2'd1; lt_v[4] = 3'b010;
`ifdef MEMWB_LOAD_ALIGN_EN
        exp_v[0] = 32'hFFFF_FF80;
        exp_v[1] = 32'h0000_00FF;
        exp_v[2] = 32'hFFFF_80FF;
        exp_v[3] = 32'h0000_7F01;
        exp_v[4] = 32'h80FF_7F01;
`else
        for (int i = 0; i < 5; i++) exp_v[i] = 32'h80FF_7F01;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer_load(32'h80FF_7F01, lo_v[i], lt_v[i]);
            tick();
            if (out_valid !== 1'b1 || out_wb_data !== exp_v[i]) begin
                errors++; $display("FAIL align_%0d: got v=%b wb=%h expected v=1 wb=%h", i, out_valid, out_wb_data, exp_v[i]);
            end
            checks++;
            $display("align: lo=%0d lt=%b wb=%h", lo_v[i], lt_v[i], out_wb_data);
        end
        in_valid    = 1'b0;
        in_memtoreg = 1'b0;
        tick();
    endtask

    task automatic test_x0();
        out_ready = 1'b1;
        offer(32'hDEAD_BEEF, 5'd0, 1'b1);
        in_vecwrite = 1'b1;
        in_vecdata  = 64'h0123_4567_89AB_CDEF;
        tick();
        in_valid = 1'b0;
        if (out_regwrite !== 1'b0 || out_wb_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL x0: got we=%b wb=%h expected 0 deadbeef", out_regwrite, out_wb_data);
        end
        checks++;
        if (out_vecwrite !== 1'b1 || out_vecdata !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL vec: got vwe=%b vec=%h expected 1 0123456789abcdef", out_vecwrite, out_vecdata);
        end
        checks++;
        tick();
        $display("x0: regwrite suppressed, wb=%h", 32'hDEAD_BEEF);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h11, 5'd1, 1'b1);
        tick();
        offer(32'h22, 5'd2, 1'b1);
        tick();
        // In TWO with a pending offer: nothing can fire on the input.
        offer(32'h33, 5'd3, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i  = 1'b0;
        in_valid = 1'b0;
        if (out_count !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_two: got cnt=%0d rdy=%b v=%b expected 0 1 0", out_count, in_ready, out_valid);
        end
        checks++;
        if (flush_drops !== 4'd2) begin
            errors++; $display("FAIL flush_drops2: got %0d expected 2", flush_drops);
        end
        checks++;
        // One held entry delivered in the flush cycle is not a drop.
        offer(32'h44, 5'd4, 1'b1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush_i   = 1'b1;
        tick();
        flush_i = 1'b0;
        if (flush_drops !== 4'd2 || out_count !== 2'd0) begin
            errors++; $display("FAIL flush_deliver: got drops=%0d cnt=%0d expected 2 0", flush_drops, out_count);
        end
        checks++;
        // Flush while accepting each cycle: one drop per cycle, then saturate.
        offer(32'h55, 5'd5, 1'b1);
        flush_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        if (flush_drops !== 4'd7) begin
            errors++; $display("FAIL flush_incr: got %0d expected 7", flush_drops);
        end
        checks++;
        for (int i = 0; i < 15; i++) tick();
        if (flush_drops !== 4'd15) begin
            errors++; $display("FAIL flush_sat: got %0d expected 15", flush_drops);
        end
        checks++;
        flush_i  = 1'b0;
        in_valid = 1'b0;
        tick();
        $display("flush: drops=%0d", flush_drops);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        offer(32'h66, 5'd6, 1'b1);
        tick();
        offer(32'h77, 5'd7, 1'b1);
        tick();
        in_valid = 1'b0;
        if (out_count !== 2'd2) begin
            errors++; $display("FAIL arst_pre: got cnt=%0d expected 2", out_count);
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (out_valid !== 1'b0 || out_count !== 2'd0 || flush_drops !== '0) begin
            errors++; $display("FAIL arst: got v=%b cnt=%0d drops=%0d expected 0 0 0", out_valid, out_count, flush_drops);
        end
        checks++;
        tick();
        rst_n = 1'b1;
        tick();
        $display("async_reset: count=%0d", out_count);
    endtask

    initial begin
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        in_valid     = 1'b0;
        in_result    = '0;
        in_ramdata   = '0;
        in_addr_lo   = '0;
        in_load_type = 3'b010;
        in_memtoreg  = 1'b0;
        in_regwrite  = 1'b0;
        in_rd        = '0;
        in_vecwrite  = 1'b0;
        in_vecdata   = '0;
        out_ready    = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_align();
        test_x0();
        test_flush();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
